// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture engine: synchronises the GB LCD bus into pixel_clk, packs pixels
// into RAM words and writes whole frames into alternating display banks.
module gb_lcd_capture #(
  parameter int unsigned SRC_W       = 160,
  parameter int unsigned SRC_H       = 144,
  parameter int unsigned BPP         = 2,
  parameter int unsigned WORD_PIX    = 4,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          INVERT      = 1'b1,
  parameter bit          DOUBLE_BUF  = 1'b1
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    GB_PClk,
  input  logic                    GB_HSync,
  input  logic                    GB_VSync,
  input  logic [BPP-1:0]          GB_Data,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [BPP*WORD_PIX-1:0] wr_data,
  output logic                    disp_bank,
  output logic [7:0]              line_cnt,
  output logic                    frame_done,
  output logic                    err_line,
  output logic                    err_frame,
  input  logic                    err_clr
);

  localparam int unsigned DW          = BPP * WORD_PIX;
  localparam int unsigned WPL         = SRC_W / WORD_PIX;
  localparam int unsigned FRAME_WORDS = SRC_H * WPL;
  localparam int unsigned PIX_W       = $clog2(SRC_W + 1);
  localparam int unsigned SUB_W       = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
  localparam int unsigned WIDX_W      = $clog2(WPL + 1);
  localparam logic [7:0]  LastLine    = 8'(SRC_H - 1);

  typedef enum logic [1:0] {StIdle, StLine, StWaitH, StDone} state_e;

  logic [SYNC_STAGES-1:0]          pclk_sync_q, hs_sync_q, vs_sync_q;
  logic [SYNC_STAGES-1:0][BPP-1:0] data_sync_q;
  logic                            pclk_prev_q;

  state_e            state_q, state_d;
  logic [7:0]        line_q, line_d, cap_line;
  logic [PIX_W-1:0]  pix_q, pix_d, pix_base;
  logic [SUB_W-1:0]  sub_q, sub_d, sub_base;
  logic [WIDX_W-1:0] widx_q, widx_d, widx_base;
  logic [DW-1:0]     shift_q, shift_d;
  logic              over_q, over_d;
  logic              bank_q, bank_d;
  logic              disp_q, disp_d;
  logic              push_q, push_d;
  logic [ADDR_W-1:0] push_addr_q, push_addr_d;
  logic              done_q, done_d;
  logic              err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DW-1:0]     wr_data_q;

  logic           fall, hs, vs, cap, cap_restart, set_line, set_frame;
  logic [BPP-1:0] pix_val;

  // HSync/VSync/Data are taken from the same stage as the current PClk sample.
  assign fall    = pclk_prev_q & ~pclk_sync_q[SYNC_STAGES-1];
  assign hs      = hs_sync_q[SYNC_STAGES-1];
  assign vs      = vs_sync_q[SYNC_STAGES-1];
  assign pix_val = INVERT ? ~data_sync_q[SYNC_STAGES-1] : data_sync_q[SYNC_STAGES-1];

  // Input synchronisers plus one extra PClk flop for falling-edge detection.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pclk_sync_q <= '0;
      hs_sync_q   <= '0;
      vs_sync_q   <= '0;
      data_sync_q <= '0;
      pclk_prev_q <= 1'b0;
    end else begin
      pclk_sync_q    <= {pclk_sync_q[SYNC_STAGES-2:0], GB_PClk};
      hs_sync_q      <= {hs_sync_q[SYNC_STAGES-2:0], GB_HSync};
      vs_sync_q      <= {vs_sync_q[SYNC_STAGES-2:0], GB_VSync};
      data_sync_q[0] <= GB_Data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      pclk_prev_q    <= pclk_sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state: frame/line sequencing, error detection and pixel packing.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    pix_d       = pix_q;
    sub_d       = sub_q;
    widx_d      = widx_q;
    shift_d     = shift_q;
    over_d      = over_q;
    bank_d      = bank_q;
    disp_d      = disp_q;
    push_d      = 1'b0;
    push_addr_d = push_addr_q;
    done_d      = 1'b0;
    set_line    = 1'b0;
    set_frame   = 1'b0;
    cap         = 1'b0;
    cap_restart = 1'b0;
    cap_line    = line_q;
    pix_base    = pix_q;
    sub_base    = sub_q;
    widx_base   = widx_q;

    unique case (state_q)
      StIdle: begin
        if (fall && hs && vs && enable) begin
          cap         = 1'b1;
          cap_restart = 1'b1;
          cap_line    = '0;
        end
      end
      StLine, StWaitH: begin
        if (fall) begin
          if (hs && vs) begin
            // Frame start wins over line rules; an early one aborts the current frame.
            if (line_q < LastLine) set_frame = 1'b1;
            else                   set_line  = 1'b1;
            if (enable) begin
              cap         = 1'b1;
              cap_restart = 1'b1;
              cap_line    = '0;
            end else begin
              state_d = StIdle;
            end
          end else if (hs) begin
            cap         = 1'b1;
            cap_restart = 1'b1;
            if (state_q == StLine) set_line = 1'b1;      // short line: redo same line
            else                   cap_line = line_q + 8'd1;
          end else if (state_q == StLine) begin
            cap = 1'b1;
          end else if (!over_q) begin
            set_line = 1'b1;
            over_d   = 1'b1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        disp_d  = bank_q;
        bank_d  = DOUBLE_BUF ? ~bank_q : 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (cap) begin
      if (cap_restart) begin
        pix_base  = '0;
        sub_base  = '0;
        widx_base = '0;
      end
      line_d  = cap_line;
      over_d  = 1'b0;
      shift_d = (shift_q << BPP) | DW'(pix_val);
      pix_d   = pix_base + 1'b1;
      if (sub_base == SUB_W'(WORD_PIX - 1)) begin
        sub_d       = '0;
        widx_d      = widx_base + 1'b1;
        push_d      = 1'b1;
        push_addr_d = (bank_q ? ADDR_W'(FRAME_WORDS) : '0) + ADDR_W'(cap_line) * ADDR_W'(WPL)
                      + ADDR_W'(widx_base);
      end else begin
        sub_d  = sub_base + 1'b1;
        widx_d = widx_base;
      end
      if (pix_d == PIX_W'(SRC_W)) state_d = (cap_line == LastLine) ? StDone : StWaitH;
      else                        state_d = StLine;
    end

    err_line_d  = err_clr ? 1'b0 : (err_line_q | set_line);
    err_frame_d = err_clr ? 1'b0 : (err_frame_q | set_frame);
  end

  // State registers; the write port is registered one cycle after the word completes.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      line_q      <= '0;
      pix_q       <= '0;
      sub_q       <= '0;
      widx_q      <= '0;
      shift_q     <= '0;
      over_q      <= 1'b0;
      bank_q      <= 1'b0;
      disp_q      <= 1'b0;
      push_q      <= 1'b0;
      push_addr_q <= '0;
      done_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      pix_q       <= pix_d;
      sub_q       <= sub_d;
      widx_q      <= widx_d;
      shift_q     <= shift_d;
      over_q      <= over_d;
      bank_q      <= bank_d;
      disp_q      <= disp_d;
      push_q      <= push_d;
      push_addr_q <= push_addr_d;
      done_q      <= done_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      wr_en_q     <= push_q;
      if (push_q) begin
        wr_addr_q <= push_addr_q;
        wr_data_q <= shift_q;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign disp_bank  = disp_q;
  assign line_cnt   = line_q;
  assign frame_done = done_q;
  assign err_line   = err_line_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Bench for gb_lcd_capture: two small-geometry instances (A: 2 sync stages, plain data,
// double-buffered; B: 3 sync stages, inverted data, single bank) share one GB bus.
module tb_gb_lcd_capture;

  localparam int W = 16;
  localparam int H = 8;
  localparam int WP = 4;
  localparam int WPL = W / WP;

  logic clk = 1'b0;
  logic rst, enable, GB_PClk, GB_HSync, GB_VSync, err_clr;
  logic [1:0] GB_Data;

  logic       wr_en_a, disp_bank_a, frame_done_a, err_line_a, err_frame_a;
  logic [5:0] wr_addr_a;
  logic [7:0] wr_data_a, line_cnt_a;
  logic       wr_en_b, disp_bank_b, frame_done_b, err_line_b, err_frame_b;
  logic [5:0] wr_addr_b;
  logic [7:0] wr_data_b, line_cnt_b;

  always #5 clk = ~clk;

  gb_lcd_capture #(
    .SRC_W(W), .SRC_H(H), .BPP(2), .WORD_PIX(WP), .ADDR_W(6), .SYNC_STAGES(2),
    .INVERT(1'b0), .DOUBLE_BUF(1'b1)
  ) u_dut_a (
    .pixel_clk(clk), .rst(rst), .enable(enable), .GB_PClk(GB_PClk), .GB_HSync(GB_HSync),
    .GB_VSync(GB_VSync), .GB_Data(GB_Data), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .disp_bank(disp_bank_a), .line_cnt(line_cnt_a),
    .frame_done(frame_done_a), .err_line(err_line_a), .err_frame(err_frame_a),
    .err_clr(err_clr)
  );

  gb_lcd_capture #(
    .SRC_W(W), .SRC_H(H), .BPP(2), .WORD_PIX(WP), .ADDR_W(6), .SYNC_STAGES(3),
    .INVERT(1'b1), .DOUBLE_BUF(1'b0)
  ) u_dut_b (
    .pixel_clk(clk), .rst(rst), .enable(enable), .GB_PClk(GB_PClk), .GB_HSync(GB_HSync),
    .GB_VSync(GB_VSync), .GB_Data(GB_Data), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .disp_bank(disp_bank_b), .line_cnt(line_cnt_b),
    .frame_done(frame_done_b), .err_line(err_line_b), .err_frame(err_frame_b),
    .err_clr(err_clr)
  );

  typedef struct {
    bit vs;
    int n;
    bit en;
    bit meas;
    bit zero;
  } line_t;

  typedef struct {
    int trunc_line;
    int trunc_len;
    int abort_after;
    int long_line;
    bit en_drop;
    bit meas;
    bit exp_el;
    bit exp_ef;
    int exp_done;
  } scen_t;

  line_t       lines[$];
  logic [1:0]  pixbuf[32][20];
  logic [13:0] wq_a[$], wq_b[$], expq_a[$], expq_b[$];
  int          done_a, done_b, lat_a, lat_b;
  int          m_bank[2], m_disp[2];
  int          n_cmp = 0;
  int          n_bad = 0;
  scen_t       tbl[6];

  // Write and frame_done monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en_a) wq_a.push_back({wr_addr_a, wr_data_a});
    if (wr_en_b) wq_b.push_back({wr_addr_b, wr_data_b});
    if (frame_done_a) done_a++;
    if (frame_done_b) done_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One GB pixel: PClk high for 4 cycles with data set up, then the falling edge.
  task automatic pix(input bit hs, input bit vs, input logic [1:0] d, input bit meas);
    @(posedge clk); #1;
    GB_PClk = 1'b1; GB_HSync = hs; GB_VSync = vs; GB_Data = d;
    repeat (4) @(posedge clk);
    #1 GB_PClk = 1'b0;
    if (meas) begin
      lat_a = -1;
      lat_b = -1;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        if (wr_en_a && lat_a < 0) lat_a = k;
        if (wr_en_b && lat_b < 0) lat_b = k;
      end
    end else begin
      repeat (3) @(posedge clk);
    end
  endtask

  // Line-level reference: which words of which lines end up in which bank.
  task automatic model(input int k, input bit inv, input bit db);
    bit          in_f;
    int          ln, prev_n, nw, addr;
    logic [7:0]  data;
    logic [1:0]  px;
    in_f = 1'b0; ln = 0; prev_n = 0;
    for (int i = 0; i < lines.size(); i++) begin
      if (lines[i].vs) begin
        in_f = lines[i].en;
        ln = 0;
      end else if (in_f && prev_n >= W) begin
        ln++;
      end
      if (in_f) begin
        nw = ((lines[i].n < W) ? lines[i].n : W) / WP;
        for (int w = 0; w < nw; w++) begin
          data = '0;
          for (int p = 0; p < WP; p++) begin
            px = pixbuf[i][w*WP+p];
            if (inv) px = ~px;
            data = {data[5:0], px};
          end
          addr = m_bank[k] * H * WPL + ln * WPL + w;
          if (k == 0) expq_a.push_back({6'(addr), data});
          else        expq_b.push_back({6'(addr), data});
        end
        prev_n = lines[i].n;
        if (lines[i].n >= W && ln == H - 1) begin
          m_disp[k] = m_bank[k];
          if (db) m_bank[k] = 1 - m_bank[k];
          in_f = 1'b0;
        end
      end
    end
  endtask

  task automatic run_scen(input scen_t s);
    int n;
    lines.delete();
    if (s.abort_after > 0)
      for (int l = 0; l < s.abort_after; l++) lines.push_back('{l == 0, W, 1'b1, 1'b0, 1'b0});
    for (int l = 0; l < H; l++) begin
      if (l == s.trunc_line) lines.push_back('{l == 0, s.trunc_len, 1'b1, 1'b0, 1'b0});
      lines.push_back('{l == 0, (l == s.long_line) ? W + 2 : W, !(s.en_drop && l > 0),
                        s.meas && l == 0, s.meas && l == 0});
    end
    if (s.en_drop)
      for (int l = 0; l < H; l++) lines.push_back('{l == 0, W, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < lines.size(); i++)
      for (int x = 0; x < lines[i].n; x++)
        pixbuf[i][x] = lines[i].zero ? 2'b00 : 2'($urandom);

    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("err_clr_line_a", {31'd0, err_line_a}, 0);
    chk("err_clr_frame_b", {31'd0, err_frame_b}, 0);
    wq_a.delete(); wq_b.delete(); expq_a.delete(); expq_b.delete();
    done_a = 0; done_b = 0;
    model(0, 1'b0, 1'b1);
    model(1, 1'b1, 1'b0);

    for (int i = 0; i < lines.size(); i++) begin
      enable = lines[i].en;
      for (int x = 0; x < lines[i].n; x++)
        pix(x == 0, lines[i].vs, pixbuf[i][x], lines[i].meas && x == WP - 1);
      repeat (6) @(posedge clk);
    end
    enable = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    chk("nwr_a", wq_a.size(), expq_a.size());
    n = (wq_a.size() < expq_a.size()) ? wq_a.size() : expq_a.size();
    for (int i = 0; i < n; i++) chk("wr_a", {18'd0, wq_a[i]}, {18'd0, expq_a[i]});
    chk("nwr_b", wq_b.size(), expq_b.size());
    n = (wq_b.size() < expq_b.size()) ? wq_b.size() : expq_b.size();
    for (int i = 0; i < n; i++) chk("wr_b", {18'd0, wq_b[i]}, {18'd0, expq_b[i]});
    chk("done_a", done_a, s.exp_done);
    chk("done_b", done_b, s.exp_done);
    chk("err_line_a", {31'd0, err_line_a}, {31'd0, s.exp_el});
    chk("err_frame_a", {31'd0, err_frame_a}, {31'd0, s.exp_ef});
    chk("err_line_b", {31'd0, err_line_b}, {31'd0, s.exp_el});
    chk("err_frame_b", {31'd0, err_frame_b}, {31'd0, s.exp_ef});
    chk("disp_a", {31'd0, disp_bank_a}, m_disp[0]);
    chk("disp_b", {31'd0, disp_bank_b}, m_disp[1]);
    if (s.meas) begin
      chk("latency_a", lat_a, 4);
      chk("latency_b", lat_b, 5);
      if (wq_b.size() > 0) chk("inv_zero_b", {24'd0, wq_b[0][7:0]}, 32'hFF);
      else                 chk("inv_zero_b_present", 0, 1);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst = 1'b1; enable = 1'b1; err_clr = 1'b0;
    GB_PClk = 1'b0; GB_HSync = 1'b0; GB_VSync = 1'b0; GB_Data = 2'b00;
    m_bank = '{0, 0}; m_disp = '{0, 0};
    //          trunc  len abort long en_d meas el ef done
    tbl[0] = '{-1,   0,  0,  -1,  0,  1,  0, 0, 1};
    tbl[1] = '{-1,   0,  0,  -1,  0,  0,  0, 0, 1};
    tbl[2] = '{ 5,  10,  0,  -1,  0,  0,  1, 0, 1};
    tbl[3] = '{-1,   0,  5,  -1,  0,  0,  0, 1, 1};
    tbl[4] = '{-1,   0,  0,   2,  0,  0,  1, 0, 1};
    tbl[5] = '{-1,   0,  0,  -1,  1,  0,  0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en_a", {31'd0, wr_en_a}, 0);
    chk("rst_wr_addr_a", {26'd0, wr_addr_a}, 0);
    chk("rst_line_cnt_b", {24'd0, line_cnt_b}, 0);
    chk("rst_disp_a", {31'd0, disp_bank_a}, 0);
    chk("rst_flags_b", {30'd0, err_line_b, err_frame_b}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int t = 0; t < 6; t++) run_scen(tbl[t]);

    // Asynchronous reset in the middle of line 3, with a word write still in flight.
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < W; x++) pix(x == 0, l == 0, 2'($urandom), 1'b0);
      repeat (6) @(posedge clk);
    end
    for (int x = 0; x < WP - 1; x++) pix(x == 0, 1'b0, 2'($urandom), 1'b0);
    @(posedge clk); #1 GB_PClk = 1'b1;
    repeat (4) @(posedge clk);
    #1 GB_PClk = 1'b0;
    repeat (2) @(posedge clk);
    n0 = wq_a.size();
    #2 rst = 1'b1;
    #1;
    chk("arst_line_cnt_a", {24'd0, line_cnt_a}, 0);
    chk("arst_disp_a", {31'd0, disp_bank_a}, 0);
    chk("arst_wr_data_a", {24'd0, wr_data_a}, 0);
    chk("arst_wr_addr_b", {26'd0, wr_addr_b}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("arst_no_write_a", wq_a.size(), n0);
    m_bank = '{0, 0}; m_disp = '{0, 0};
    run_scen(tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
